// File: rtl/fft4_sched.sv
// Radix-2 4-point FFT scheduler: loads four samples, drives a shared external
// butterfly for four in-place ops, then streams bins in natural order.
module fft4_sched #(
  parameter logic [2:0] K_QUARTER = 3'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_real,
  input  logic [15:0] in_im,
  output logic [2:0]  bf_k,
  output logic [15:0] bf_a_real,
  output logic [15:0] bf_a_im,
  output logic [15:0] bf_b_real,
  output logic [15:0] bf_b_im,
  input  logic [15:0] bf_oa_real,
  input  logic [15:0] bf_oa_im,
  input  logic [15:0] bf_ob_real,
  input  logic [15:0] bf_ob_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_real,
  output logic [15:0] out_im,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {LOAD, BF, OUT} state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic        r_frame_done;
  logic [15:0] r_re [4];
  logic [15:0] r_im [4];

  logic [1:0]  w_ia, w_ib, w_os;
  logic        w_in_acc, w_out_acc;

  // Operand pairs for the two DIT stages: stride-2 pairs first, then adjacent.
  always_comb begin
    w_ia = 2'd0;
    w_ib = 2'd2;
    case (r_idx)
      2'd0: begin w_ia = 2'd0; w_ib = 2'd2; end
      2'd1: begin w_ia = 2'd1; w_ib = 2'd3; end
      2'd2: begin w_ia = 2'd0; w_ib = 2'd1; end
      default: begin w_ia = 2'd2; w_ib = 2'd3; end
    endcase
  end

  // Results sit in bit-reversed slots, so read back with idx reversed.
  assign w_os      = {r_idx[0], r_idx[1]};
  assign w_in_acc  = (r_state == LOAD) && in_valid;
  assign w_out_acc = (r_state == OUT) && out_ready;

  assign in_ready   = (r_state == LOAD);
  assign busy       = (r_state != LOAD);
  assign out_valid  = (r_state == OUT);
  assign frame_done = r_frame_done;

  assign out_real  = (r_state == OUT) ? r_re[w_os] : 16'd0;
  assign out_im    = (r_state == OUT) ? r_im[w_os] : 16'd0;
  assign bf_k      = (r_state == BF && r_idx == 2'd3) ? K_QUARTER : 3'd0;
  assign bf_a_real = (r_state == BF) ? r_re[w_ia] : 16'd0;
  assign bf_a_im   = (r_state == BF) ? r_im[w_ia] : 16'd0;
  assign bf_b_real = (r_state == BF) ? r_re[w_ib] : 16'd0;
  assign bf_b_im   = (r_state == BF) ? r_im[w_ib] : 16'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD;
      r_idx        <= 2'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        LOAD: if (w_in_acc) begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= BF;
        end
        BF: begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= OUT;
        end
        OUT: if (w_out_acc) begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_state      <= LOAD;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state <= LOAD;
          r_idx   <= 2'd0;
        end
      endcase
    end
  end

  // Sample buffer is not reset; a fresh frame always overwrites all four slots.
  always_ff @(posedge clk) begin
    if (w_in_acc) begin
      r_re[r_idx] <= in_real;
      r_im[r_idx] <= in_im;
    end else if (r_state == BF) begin
      r_re[w_ia] <= bf_oa_real;
      r_im[w_ia] <= bf_oa_im;
      r_re[w_ib] <= bf_ob_real;
      r_im[w_ib] <= bf_ob_im;
    end
  end

endmodule

// File: tb/tb_fft4_sched.sv
// Bench for fft4_sched: external butterfly model plus a direct-DFT reference.
module tb_fft4_sched;
  localparam logic [2:0] KQ = 3'd2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy, frame_done;
  logic [15:0] in_real = '0, in_im = '0, out_real, out_im;
  logic [2:0]  bf_k;
  logic [15:0] bf_a_real, bf_a_im, bf_b_real, bf_b_im;
  logic [15:0] bf_oa_real, bf_oa_im, bf_ob_real, bf_ob_im;
  logic [15:0] wr, wi;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fft4_sched #(.K_QUARTER(KQ)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_im(in_im), .bf_k(bf_k),
    .bf_a_real(bf_a_real), .bf_a_im(bf_a_im), .bf_b_real(bf_b_real), .bf_b_im(bf_b_im),
    .bf_oa_real(bf_oa_real), .bf_oa_im(bf_oa_im), .bf_ob_real(bf_ob_real), .bf_ob_im(bf_ob_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_im(out_im),
    .busy(busy), .frame_done(frame_done));

  // Shared butterfly: k indexes W8, so even k is a rotation by k/2 quarter turns.
  always_comb begin
    wr = bf_b_real;
    wi = bf_b_im;
    case (bf_k[2:1])
      2'd0: begin wr = bf_b_real;  wi = bf_b_im;    end
      2'd1: begin wr = bf_b_im;    wi = -bf_b_real; end
      2'd2: begin wr = -bf_b_real; wi = -bf_b_im;   end
      default: begin wr = -bf_b_im; wi = bf_b_real; end
    endcase
  end
  assign bf_oa_real = bf_a_real + wr;
  assign bf_oa_im   = bf_a_im + wi;
  assign bf_ob_real = bf_a_real - wr;
  assign bf_ob_im   = bf_a_im - wi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // X[k] = sum x[n] * (-j)^(n*k), all arithmetic modulo 2^16.
  function automatic void dft(input logic [3:0][15:0] xr, xi,
                              output logic [3:0][15:0] yr, yi);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ar, ai;
      ar = '0; ai = '0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: begin ar = ar + xr[n]; ai = ai + xi[n]; end
          1: begin ar = ar + xi[n]; ai = ai - xr[n]; end
          2: begin ar = ar - xr[n]; ai = ai - xi[n]; end
          default: begin ar = ar - xi[n]; ai = ai + xr[n]; end
        endcase
      end
      yr[k] = ar; yi[k] = ai;
    end
  endfunction

  // Leaves in_valid high; returns at the negedge after the accepting edge.
  task automatic push(input logic [15:0] re, input logic [15:0] im);
    int n;
    n = 0;
    in_valid = 1'b1; in_real = re; in_im = im;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_wait", 32'(in_ready), 1);
    chk("acc_idle", 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic collect(input logic [3:0][15:0] xr, xi, input int stall, output int lat);
    logic [3:0][15:0] yr, yi;
    logic [15:0] hr, hi;
    int n;
    dft(xr, xi, yr, yi);
    out_ready = 1'b1;
    lat = 0;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (b == 0) lat = n;
      chk("out_wait", 32'(out_valid), 1);
      chk("bf_idle", 32'(|{bf_k, bf_a_real, bf_a_im, bf_b_real, bf_b_im}), 0);
      if (b == stall) begin
        out_ready = 1'b0;
        hr = out_real; hi = out_im;
        repeat (3) begin
          @(negedge clk);
          chk("hold_v", 32'(out_valid), 1);
          chk("hold_d", {out_real, out_im}, {hr, hi});
        end
        out_ready = 1'b1;
      end
      chk($sformatf("x%0d_re", b), 32'(out_real), 32'(yr[b]));
      chk($sformatf("x%0d_im", b), 32'(out_im), 32'(yi[b]));
      chk("fd_early", 32'(frame_done), 0);
      @(negedge clk);
    end
    chk("fd_pulse", 32'(frame_done), 1);
  endtask

  task automatic run_frame(input logic [3:0][15:0] xr, xi, input int stall);
    int lat;
    for (int i = 0; i < 4; i++) push(xr[i], xi[i]);
    in_valid = 1'b0;
    collect(xr, xi, stall, lat);
    chk("lat", 32'(lat), 4);
  endtask

  initial begin
    logic [3:0][15:0] fr, fi, gr, gi;
    int lat;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_bf", 32'(|{bf_k, bf_a_real, bf_a_im, bf_b_real, bf_b_im}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 1);

    // Impulse, with BF phase inspected and in_valid/out_ready junk during BF
    fr = {16'd0, 16'd0, 16'd0, 16'd1}; fi = '0;
    for (int i = 0; i < 4; i++) push(fr[i], fi[i]);
    in_valid = 1'b1; in_real = 16'h7777; in_im = 16'h5555; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("bf_busy", 32'(busy), 1);
      chk("bf_nordy", 32'(in_ready), 0);
      chk("bf_noout", 32'(out_valid), 0);
      chk("bf_k", 32'(bf_k), (c == 3) ? 32'(KQ) : 32'd0);
      if (c == 0) chk("bf_op0_a", 32'(bf_a_real), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect(fr, fi, -1, lat);
    chk("imp_lat", 32'(lat), 0);
    @(negedge clk);
    chk("fd_one_cycle", 32'(frame_done), 0);

    // DC, shifted impulse, backpressure on X1
    fr = {16'd1, 16'd1, 16'd1, 16'd1}; fi = '0;
    run_frame(fr, fi, -1);
    fr = {16'd0, 16'd0, 16'd1, 16'd0}; fi = '0;
    run_frame(fr, fi, -1);
    for (int i = 0; i < 4; i++) begin fr[i] = 16'($urandom); fi[i] = 16'($urandom); end
    run_frame(fr, fi, 1);

    // Random frames, random stall beat (4 = none)
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++) begin fr[i] = 16'($urandom); fi[i] = 16'($urandom); end
      run_frame(fr, fi, int'($urandom_range(0, 4)));
    end

    // Reset during BF op 2
    for (int i = 0; i < 4; i++) push(16'h1234, 16'h0042);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", 32'(out_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_fd", 32'(frame_done), 0);
    chk("mrst_bf", 32'(|{bf_k, bf_a_real, bf_a_im, bf_b_real, bf_b_im}), 0);
    chk("mrst_out", {out_real, out_im}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mrst_quiet", 32'(out_valid), 0);
    end
    chk("mrst_rdy", 32'(in_ready), 1);
    fr = {16'd1, 16'd1, 16'd1, 16'd1}; fi = '0;
    run_frame(fr, fi, -1);

    // Streaming: in_valid held high across two frames
    for (int i = 0; i < 4; i++) begin
      fr[i] = 16'($urandom); fi[i] = 16'($urandom);
      gr[i] = 16'($urandom); gi[i] = 16'($urandom);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) push(fr[i], fi[i]);
        for (int i = 0; i < 4; i++) push(gr[i], gi[i]);
        in_valid = 1'b0;
      end
      begin
        int l0, l1;
        collect(fr, fi, -1, l0);
        collect(gr, gi, 2, l1);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
